// File: rtl/mux94_arbiter.sv
// Round-robin arbiter/sequencer sharing one 4-input 9-bit latching mux among four sources.
// Drives mux sel/lat/reset and returns a one-hot grant once the selected input is latched.
module mux94_arbiter #(
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned MAX_HOLD   = 16,
  parameter int unsigned HW         = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] mux_sel,
  output logic       mux_lat,
  output logic       mux_clr,
  output logic       busy,
  output logic [1:0] owner
);

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StHold
  } state_e;

  localparam logic [3:0]    SettleInit  = 4'(SETTLE_CYC - 1);
  localparam bit            HoldLimited = (MAX_HOLD != 0);
  localparam logic [HW-1:0] HoldLast    = HW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  state_e        state_q;
  logic [3:0]    settle_q;
  logic [HW-1:0] hold_q;

  logic [1:0] next_owner;
  logic [1:0] cand;
  logic       found;
  logic       owner_req;
  logic       hold_expired;

  // Scan owner+1, owner+2, ... so the last owner is considered last.
  always_comb begin
    next_owner = owner;
    cand       = '0;
    found      = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cand = owner + 2'(i);
      if (!found && req[cand]) begin
        next_owner = cand;
        found      = 1'b1;
      end
    end
  end

  assign owner_req    = req[owner];
  assign hold_expired = HoldLimited && (hold_q == HoldLast);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      settle_q <= '0;
      hold_q   <= '0;
      gnt      <= '0;
      mux_sel  <= '0;
      mux_lat  <= 1'b0;
      mux_clr  <= 1'b1;
      busy     <= 1'b0;
      owner    <= 2'd3;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (found) begin
            mux_sel  <= next_owner;
            owner    <= next_owner;
            mux_clr  <= 1'b0;
            busy     <= 1'b1;
            settle_q <= SettleInit;
            state_q  <= StSettle;
          end
        end
        StSettle: begin
          if (!owner_req) begin
            // Owner is kept so the aborted source ranks lowest next time.
            mux_clr <= 1'b1;
            busy    <= 1'b0;
            state_q <= StIdle;
          end else if (settle_q == '0) begin
            mux_lat <= 1'b1;
            gnt     <= 4'b0001 << owner;
            hold_q  <= '0;
            state_q <= StHold;
          end else begin
            settle_q <= settle_q - 4'd1;
          end
        end
        StHold: begin
          hold_q <= hold_q + HW'(1);
          if (!owner_req || hold_expired) begin
            gnt     <= '0;
            mux_lat <= 1'b0;
            mux_clr <= 1'b1;
            busy    <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: begin
          gnt     <= '0;
          mux_lat <= 1'b0;
          mux_clr <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux94_arbiter.sv
// Directed bench for mux94_arbiter: latency, rotation, release, abort, async reset, unlimited hold.
module tb_mux94_arbiter;

  logic       clk = 1'b0;
  logic       rst_n0, rst_n1;
  logic [3:0] req, req1;
  logic [3:0] gnt, gnt1;
  logic [1:0] mux_sel, mux_sel1, owner, owner1;
  logic       mux_lat, mux_clr, busy, mux_lat1, mux_clr1, busy1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mux94_arbiter #(.SETTLE_CYC(2), .MAX_HOLD(16), .HW(8)) dut (
    .clk(clk), .reset_n(rst_n0), .req(req), .gnt(gnt), .mux_sel(mux_sel),
    .mux_lat(mux_lat), .mux_clr(mux_clr), .busy(busy), .owner(owner)
  );

  mux94_arbiter #(.SETTLE_CYC(2), .MAX_HOLD(0), .HW(8)) dut_unl (
    .clk(clk), .reset_n(rst_n1), .req(req1), .gnt(gnt1), .mux_sel(mux_sel1),
    .mux_lat(mux_lat1), .mux_clr(mux_clr1), .busy(busy1), .owner(owner1)
  );

  // Output invariants, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n0) begin
      checks++;
      if (gnt != 4'b0000 && !(mux_lat && !mux_clr)) begin
        failures++;
        $display("FAIL inv_gnt_lat_clr gnt=%b lat=%b clr=%b", gnt, mux_lat, mux_clr);
      end
      checks++;
      if ((gnt & (gnt - 4'd1)) != 4'b0000) begin
        failures++;
        $display("FAIL inv_onehot gnt=%b", gnt);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n0 = 1'b0; rst_n1 = 1'b0; req = '0; req1 = '0;
    #12;
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL rst_gnt got=%b exp=0000", gnt); end
    checks++; if (mux_sel !== 2'd0) begin failures++; $display("FAIL rst_sel got=%0d exp=0", mux_sel); end
    checks++; if (mux_lat !== 1'b0) begin failures++; $display("FAIL rst_lat got=%b exp=0", mux_lat); end
    checks++; if (mux_clr !== 1'b1) begin failures++; $display("FAIL rst_clr got=%b exp=1", mux_clr); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (owner !== 2'd3) begin failures++; $display("FAIL rst_owner got=%0d exp=3", owner); end
    tick();
    rst_n0 = 1'b1; rst_n1 = 1'b1;
  endtask

  task automatic test_latency();
    req = 4'b0100;
    tick();
    checks++; if (mux_sel !== 2'd2) begin failures++; $display("FAIL lat_sel got=%0d exp=2", mux_sel); end
    checks++; if (mux_clr !== 1'b0 || gnt !== 4'b0000 || busy !== 1'b1) begin
      failures++; $display("FAIL lat_settle1 clr=%b gnt=%b busy=%b exp 0/0000/1", mux_clr, gnt, busy); end
    tick();
    checks++; if (gnt !== 4'b0000 || mux_lat !== 1'b0 || mux_clr !== 1'b0) begin
      failures++; $display("FAIL lat_settle2 gnt=%b lat=%b clr=%b exp 0000/0/0", gnt, mux_lat, mux_clr); end
    tick();
    checks++; if (gnt !== 4'b0100 || mux_lat !== 1'b1 || mux_clr !== 1'b0) begin
      failures++; $display("FAIL lat_grant gnt=%b lat=%b clr=%b exp 0100/1/0", gnt, mux_lat, mux_clr); end
    req = 4'b0000;
    tick();
    checks++; if (gnt !== 4'b0000 || mux_clr !== 1'b1 || busy !== 1'b0 || owner !== 2'd2) begin
      failures++; $display("FAIL lat_release gnt=%b clr=%b busy=%b owner=%0d exp 0000/1/0/2",
                           gnt, mux_clr, busy, owner); end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_gnt;
    int hold_bad;
    rst_n0 = 1'b0;
    #1;
    rst_n0 = 1'b1;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_gnt = 4'b0001 << (k % 4);
      tick();
      checks++; if (owner !== 2'(k % 4) || mux_sel !== 2'(k % 4) || mux_clr !== 1'b0 || gnt !== 4'b0000) begin
        failures++; $display("FAIL rot_settle k=%0d owner=%0d sel=%0d clr=%b gnt=%b exp owner %0d",
                             k, owner, mux_sel, mux_clr, gnt, k % 4); end
      tick();
      checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL rot_settle2 k=%0d gnt=%b exp=0000", k, gnt); end
      hold_bad = 0;
      for (int c = 0; c < 16; c++) begin
        tick();
        if (gnt !== exp_gnt || mux_lat !== 1'b1) hold_bad++;
      end
      checks++; if (hold_bad != 0) begin
        failures++; $display("FAIL rot_hold k=%0d bad_cycles=%0d exp=0 gnt=%b exp_gnt=%b", k, hold_bad, gnt, exp_gnt); end
      tick();
      checks++; if (gnt !== 4'b0000 || mux_clr !== 1'b1 || mux_lat !== 1'b0 || busy !== 1'b0) begin
        failures++; $display("FAIL rot_gap k=%0d gnt=%b clr=%b lat=%b busy=%b exp 0000/1/0/0",
                             k, gnt, mux_clr, mux_lat, busy); end
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_drop_in_hold();
    req = 4'b0010;
    tick(); tick(); tick();
    checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL drop_hold_grant gnt=%b exp=0010", gnt); end
    tick();
    req = 4'b1000;
    tick();
    checks++; if (gnt !== 4'b0000 || mux_clr !== 1'b1) begin
      failures++; $display("FAIL drop_release gnt=%b clr=%b exp 0000/1", gnt, mux_clr); end
    tick();
    checks++; if (owner !== 2'd3 || mux_sel !== 2'd3) begin
      failures++; $display("FAIL drop_next_owner owner=%0d sel=%0d exp=3", owner, mux_sel); end
    tick();
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL drop_settle gnt=%b exp=0000", gnt); end
    tick();
    checks++; if (gnt !== 4'b1000 || mux_lat !== 1'b1) begin
      failures++; $display("FAIL drop_regrant gnt=%b lat=%b exp 1000/1", gnt, mux_lat); end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_settle_abort();
    int any_gnt;
    req = 4'b0001;
    tick();
    checks++; if (owner !== 2'd0 || busy !== 1'b1) begin
      failures++; $display("FAIL abort_settle owner=%0d busy=%b exp 0/1", owner, busy); end
    req = 4'b0000;
    any_gnt = 0;
    tick();
    checks++; if (mux_clr !== 1'b1 || busy !== 1'b0 || owner !== 2'd0) begin
      failures++; $display("FAIL abort_idle clr=%b busy=%b owner=%0d exp 1/0/0", mux_clr, busy, owner); end
    for (int c = 0; c < 4; c++) begin
      if (gnt !== 4'b0000) any_gnt++;
      tick();
    end
    checks++; if (any_gnt != 0) begin failures++; $display("FAIL abort_no_gnt cycles=%0d exp=0", any_gnt); end
    req = 4'b0011;
    tick();
    checks++; if (owner !== 2'd1 || mux_sel !== 2'd1) begin
      failures++; $display("FAIL abort_next owner=%0d sel=%0d exp=1", owner, mux_sel); end
    tick(); tick();
    checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL abort_grant gnt=%b exp=0010", gnt); end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_async_reset();
    req = 4'b1000;
    tick(); tick(); tick();
    checks++; if (gnt !== 4'b1000) begin failures++; $display("FAIL ar_hold gnt=%b exp=1000", gnt); end
    #2;
    rst_n0 = 1'b0;
    #1;
    checks++; if (gnt !== 4'b0000 || mux_lat !== 1'b0 || mux_clr !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL ar_immediate gnt=%b lat=%b clr=%b busy=%b exp 0000/0/1/0",
                           gnt, mux_lat, mux_clr, busy); end
    #1;
    rst_n0 = 1'b1;
    tick();
    checks++; if (owner !== 2'd3 || mux_sel !== 2'd3 || busy !== 1'b1) begin
      failures++; $display("FAIL ar_resume owner=%0d sel=%0d busy=%b exp 3/3/1", owner, mux_sel, busy); end
    tick(); tick();
    checks++; if (gnt !== 4'b1000) begin failures++; $display("FAIL ar_grant gnt=%b exp=1000", gnt); end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_unlimited_hold();
    int bad;
    req1 = 4'b0010;
    tick(); tick(); tick();
    checks++; if (gnt1 !== 4'b0010) begin failures++; $display("FAIL unl_grant gnt=%b exp=0010", gnt1); end
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (gnt1 !== 4'b0010 || mux_lat1 !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL unl_hold bad_cycles=%0d exp=0", bad); end
    req1 = 4'b0000;
    tick();
    checks++; if (gnt1 !== 4'b0000 || mux_clr1 !== 1'b1) begin
      failures++; $display("FAIL unl_release gnt=%b clr=%b exp 0000/1", gnt1, mux_clr1); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_rotation();
    test_drop_in_hold();
    test_settle_abort();
    test_async_reset();
    test_unlimited_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
